xbar_rr_arbiter: RTL
====================

Name: xbar_rr_arbiter

Overview:
- Upstream control stage for the configurable crossbar mux. Produces the crossbar's source select (SEL) and destination select (ESEL).
- Arbitrates among N_IN requesters using round-robin order. Holds a grant until the transfer completes, the requester withdraws, or (optionally) a timeout expires.
- All outputs are registered, so the crossbar sees stable selects for the whole transfer.

Parameters:
- N_IN, 4, number of requesters/crossbar inputs (same value as the crossbar data width constant).
- SEL_W, 2, select width; must equal clog2(N_IN).
- MAX_HOLD, 8, maximum grant length in cycles, used only with XBAR_TIMEOUT_EN; legal range 1..255.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset; synchronous and active-high.
- REQ  in  N_IN  per-requester request, level-sensitive.
- DEST  in  N_IN*SEL_W  per-requester destination; slice i is DEST[i*SEL_W +: SEL_W].
- DONE  in  1  transfer-complete strobe from the consumer, sampled only while VALID=1.
- SEL  out  SEL_W  index of the granted source, driven to crossbar SEL.
- ESEL  out  SEL_W  destination of the granted source, driven to crossbar ESEL.
- GNT  out  N_IN  one-hot grant vector, or all zeros.
- VALID  out  1  SEL/ESEL/GNT are meaningful.
- TIMEOUT  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (RST=1 at a clock edge, including mid-grant):
  - SEL=0, ESEL=0, GNT=0, VALID=0, TIMEOUT=0.
  - Round-robin pointer PTR=0, hold counter=0, state=IDLE.
- Two states, IDLE and BUSY.
- IDLE:
  - If REQ==0, stay in IDLE with all outputs at their reset values.
  - Otherwise pick the winner w = the first i with REQ[i]=1, searching PTR, PTR+1, ... modulo N_IN.
  - At the next edge: SEL=w, ESEL=DEST slice w (captured at that edge and held), GNT=1<<w, VALID=1, counter=0, state→BUSY.
  - Latency from REQ sampled high to VALID high is 1 cycle.
- BUSY:
  - SEL, ESEL and GNT are frozen; changes on DEST are ignored.
  - Release condition: DONE=1, or REQ[w]=0, or (XBAR_TIMEOUT_EN and counter==MAX_HOLD-1).
  - On release, at the next edge: VALID=0, GNT=0, SEL=0, ESEL=0, PTR=(w+1) mod N_IN (wraps N_IN-1→0), state→IDLE.
  - If not releasing, counter increments by 1 each cycle.
- Every release is followed by exactly one IDLE cycle; there are no back-to-back grants.
  - Consequence: VALID is never high on two adjacent transfers without a low cycle between them.
- DONE and timeout on the same cycle: treated as a normal DONE release; TIMEOUT stays 0.
- DONE while VALID=0: ignored.
- The counter is SEL_W+8 bits wide; it never wraps because release occurs first.

Optional Feature:
- XBAR_TIMEOUT_EN defined:
  - The MAX_HOLD release is active, so VALID stays high for at most MAX_HOLD cycles.
  - TIMEOUT=1 for exactly the cycle in which VALID first returns to 0 after a forced release.
- XBAR_TIMEOUT_EN undefined:
  - No hold counter is built.
  - A grant ends only on DONE or REQ withdrawal.
  - The TIMEOUT port remains and is tied to 0.

Decomposition:
- Shared package/include xbar_pkg holds:
  - the N_IN and SEL_W defaults (same source as the crossbar's width constants);
  - the state encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1;
  - the MAX_HOLD default.
- One combinational sub-module, rr_pick:
  - Inputs: REQ, PTR.
  - Outputs: winner index and an any-request flag, using a rotate / priority-encode / un-rotate structure.
- All state and registers live in xbar_rr_arbiter.

Test Plan:
- Reset: hold RST=1 for 2 cycles with REQ=4'b1111 → VALID=0, GNT=0000, SEL=0, ESEL=0, TIMEOUT=0; the first grant after RST drops goes to requester 0.
- Single request: REQ=4'b0100, DEST slice 2=2'd3 at edge t → at t+1 GNT=0100, SEL=2, ESEL=3, VALID=1; DONE=1 at t+3 → VALID=0 and GNT=0 at t+4.
- Fairness: REQ=4'b1111 held, DONE pulsed on every grant's first cycle → grant sequence 0,1,2,3,0, each with VALID high 1 cycle and low 1 cycle.
- Pointer wrap: complete a grant to 3, then REQ=4'b1001 → next grant goes to 0, not 3.
- Withdrawal and DEST freeze: requester 1 granted with ESEL=2; DEST slice 1 is changed to 0 mid-grant → ESEL stays 2; REQ[1] is dropped → VALID=0 next edge.
- Timeout (XBAR_TIMEOUT_EN, MAX_HOLD=8): REQ=4'b0010 held, no DONE → VALID high exactly 8 cycles, then TIMEOUT=1 for 1 cycle with VALID=0, then requester 1 re-granted. Rerun without the macro → VALID stays high indefinitely and TIMEOUT stays 0.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared constants for the crossbar round-robin arbiter: default sizes and
// the two-state control encoding.
package xbar_pkg;

  localparam int N_IN_DEF     = 4;
  localparam int SEL_W_DEF    = 2;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate requests so PTR sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_IN-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] win_o,
  output logic             any_o
);

  logic [2*N_IN-1:0] dbl;
  logic [2*N_IN-1:0] shifted;
  logic [N_IN-1:0]   rot;
  logic [SEL_W-1:0]  idx;
  logic              found;
  logic [SEL_W:0]    sum;

  always_comb begin
    dbl     = {req_i, req_i};
    shifted = dbl >> ptr_i;
    rot     = shifted[N_IN-1:0];
    idx     = '0;
    found   = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (!found && rot[i]) begin
        idx   = SEL_W'(i);
        found = 1'b1;
      end
    end
    // Un-rotate modulo N_IN so non-power-of-two sizes also wrap correctly.
    sum = {1'b0, idx} + {1'b0, ptr_i};
    if (sum >= (SEL_W+1)'(N_IN)) begin
      sum = sum - (SEL_W+1)'(N_IN);
    end
    win_o = sum[SEL_W-1:0];
    any_o = |req_i;
  end

endmodule

// File: rtl/xbar_rr_arbiter.sv
// Round-robin grant/select controller feeding the crossbar SEL/ESEL inputs.
// Define XBAR_TIMEOUT_EN to build the MAX_HOLD forced-release counter.
module xbar_rr_arbiter
  import xbar_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_IN-1:0]       REQ,
  input  logic [N_IN*SEL_W-1:0] DEST,
  input  logic                  DONE,
  output logic [SEL_W-1:0]      SEL,
  output logic [SEL_W-1:0]      ESEL,
  output logic [N_IN-1:0]       GNT,
  output logic                  VALID,
  output logic                  TIMEOUT
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] esel_q, esel_d;
  logic [N_IN-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] win;
  logic             any_req;
  logic             rel_timeout;

  rr_pick #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_pick (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .win_o (win),
    .any_o (any_req)
  );

`ifdef XBAR_TIMEOUT_EN
  localparam int CNT_W = SEL_W + 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  assign rel_timeout = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign TIMEOUT     = tmo_q;
`else
  assign rel_timeout = 1'b0;
  assign TIMEOUT     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    esel_d  = esel_q;
    gnt_d   = gnt_q;
`ifdef XBAR_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d    = ST_BUSY;
          sel_d      = win;
          esel_d     = DEST[win*SEL_W +: SEL_W];
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
`ifdef XBAR_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      ST_BUSY: begin
        if (DONE || !REQ[sel_q] || rel_timeout) begin
          state_d = ST_IDLE;
          sel_d   = '0;
          esel_d  = '0;
          gnt_d   = '0;
          ptr_d   = (sel_q == SEL_W'(N_IN - 1)) ? '0 : sel_q + 1'b1;
`ifdef XBAR_TIMEOUT_EN
          // A timeout that coincides with DONE or withdrawal is a normal release.
          tmo_d   = rel_timeout && !DONE && REQ[sel_q];
`endif
        end else begin
`ifdef XBAR_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      esel_q  <= '0;
      gnt_q   <= '0;
`ifdef XBAR_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      esel_q  <= esel_d;
      gnt_q   <= gnt_d;
`ifdef XBAR_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign SEL   = sel_q;
  assign ESEL  = esel_q;
  assign GNT   = gnt_q;
  assign VALID = (state_q == ST_BUSY);

endmodule
